step_controller: RTL and testbench

- Board-level sequencer between the push-buttons/switches and the pipelined processor.
- Debounces the step and run keys and issues single-cycle `step_en` pulses that act as the pipeline's clock enable.
- Modes: single-step, free-run at a divided rate, and halt on a PC breakpoint.
- Sequences the register-select index sent to the pipeline's debug read port, either from switches or by auto-scanning all 32 registers for the HEX display.

---
 rtl/step_controller_if.sv | 15 +
 rtl/step_controller.sv | 137 +++++++++++++
 tb/tb_step_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/step_controller_if.sv
// Pipeline-facing bundle of the step controller: advance pulse, debug
// register select and status out; retired PC back in.
interface step_controller_if;
  logic        step_en;
  logic [4:0]  reg_sel;
  logic        running;
  logic        bp_hit;
  logic [15:0] step_count;
  logic [31:0] pc_value;

  modport master (output step_en, reg_sel, running, bp_hit, step_count,
                  input  pc_value);
  modport slave  (input  step_en, reg_sel, running, bp_hit, step_count,
                  output pc_value);
endinterface

// File: rtl/step_controller.sv
// Board sequencer: debounced step/run keys drive a single-cycle pipeline
// clock enable (single-step, divided free-run, PC breakpoint) and a debug reg index.
module step_controller #(
  parameter logic [15:0] DB_CYCLES = 16'd50000,
  parameter logic [31:0] RUN_DIV   = 32'd12500000,
  parameter logic [31:0] SCAN_DIV  = 32'd50000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      key_step_n,
  input  logic                      key_run_n,
  input  logic [4:0]                sw_sel,
  input  logic                      sw_scan,
  input  logic                      bp_en,
  input  logic [7:0]                bp_addr,
  step_controller_if.master         bus
);
  localparam int NUM_KEYS = 2;  // bit 0 = step, bit 1 = run

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_BREAK} state_t;

  logic [NUM_KEYS-1:0]       sync1, sync2, db_lvl, press;
  logic [NUM_KEYS-1:0][15:0] db_cnt;
  state_t                    state;
  logic [31:0]               rate_cnt, scan_cnt;
  logic                      first;
  logic                      step_p, run_p;
  logic                      unused_pc;

  assign step_p    = press[0];
  assign run_p     = press[1];
  assign unused_pc = ^bus.pc_value[31:8];

  // Keys are active-low; "released" is the high level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '1;
      sync2  <= '1;
      db_lvl <= '1;
      db_cnt <= '0;
      press  <= '0;
    end else begin
      sync1 <= {key_run_n, key_step_n};
      sync2 <= sync1;
      for (int k = 0; k < NUM_KEYS; k++) begin
        press[k] <= 1'b0;
        if (sync2[k] == db_lvl[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_CYCLES) begin
          db_lvl[k] <= sync2[k];
          db_cnt[k] <= '0;
          press[k]  <= ~sync2[k];
        end else begin
          db_cnt[k] <= db_cnt[k] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      rate_cnt       <= '0;
      first          <= 1'b0;
      bus.step_en    <= 1'b0;
      bus.running    <= 1'b0;
      bus.bp_hit     <= 1'b0;
      bus.step_count <= '0;
    end else begin
      bus.step_en    <= 1'b0;
      bus.step_count <= bus.step_count + {15'd0, bus.step_en};
      case (state)
        S_IDLE: begin
          if (run_p) begin
            state       <= S_RUN;
            bus.running <= 1'b1;
            rate_cnt    <= '0;
            first       <= 1'b1;
          end else if (step_p) begin
            bus.step_en <= 1'b1;
          end
        end
        S_RUN: begin
          // A run press wins over a step falling due in the same cycle.
          if (run_p) begin
            state       <= S_IDLE;
            bus.running <= 1'b0;
          end else if (rate_cnt == RUN_DIV - 32'd1) begin
            rate_cnt <= '0;
            if (!first && bp_en && bus.pc_value[7:0] == bp_addr) begin
              state       <= S_BREAK;
              bus.running <= 1'b0;
              bus.bp_hit  <= 1'b1;
            end else begin
              bus.step_en <= 1'b1;
              first       <= 1'b0;
            end
          end else begin
            rate_cnt <= rate_cnt + 32'd1;
          end
        end
        S_BREAK: begin
          // Re-entering RUN skips the check once so execution can leave the bp PC.
          if (run_p) begin
            state       <= S_RUN;
            bus.running <= 1'b1;
            bus.bp_hit  <= 1'b0;
            rate_cnt    <= '0;
            first       <= 1'b1;
          end else if (step_p) begin
            bus.step_en <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          bus.running <= 1'b0;
          bus.bp_hit  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.reg_sel <= '0;
      scan_cnt    <= '0;
    end else if (!sw_scan) begin
      bus.reg_sel <= sw_sel;
      scan_cnt    <= '0;
    end else if (scan_cnt == SCAN_DIV - 32'd1) begin
      bus.reg_sel <= bus.reg_sel + 5'd1;
      scan_cnt    <= '0;
    end else begin
      scan_cnt <= scan_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller: reg-select vector table plus
// hand-timed key, run, breakpoint, scan and reset sequences.
module tb_step_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic       key_step_n, key_run_n;
  logic [4:0] sw_sel;
  logic       sw_scan, bp_en;
  logic [7:0] bp_addr;
  int         checks = 0;
  int         errors = 0;

  step_controller_if bus();

  step_controller #(.DB_CYCLES(16'd4), .RUN_DIV(32'd8), .SCAN_DIV(32'd5)) dut (
    .clk(clk), .reset(reset), .key_step_n(key_step_n), .key_run_n(key_run_n),
    .sw_sel(sw_sel), .sw_scan(sw_scan), .bp_en(bp_en), .bp_addr(bp_addr),
    .bus(bus.master));

  always #5 clk = ~clk;

  typedef struct {
    logic       scan;
    logic [4:0] sel;
    logic [4:0] exp_sel;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    int   pt[8];
    int   np;
    int   first_t;

    reset = 1'b1; key_step_n = 1'b1; key_run_n = 1'b1;
    sw_sel = '0; sw_scan = 1'b0; bp_en = 1'b0; bp_addr = '0;
    bus.pc_value = '0;
    do_reset();

    // Idle after reset: everything quiet.
    for (int t = 0; t < 20; t++) begin
      tick();
      chk("idle_outputs", {bus.step_en, bus.running, bus.bp_hit, bus.reg_sel, bus.step_count}, 0);
    end

    // Short glitch is filtered.
    np = 0;
    for (int t = 0; t < 15; t++) begin
      key_step_n = !(t < 3);
      tick();
      if (bus.step_en) np++;
    end
    chk("glitch_no_step", np, 0);

    // Held step key in IDLE: one pulse, raw-to-step_en latency 7.
    np = 0; first_t = -1;
    for (int t = 0; t < 40; t++) begin
      key_step_n = !(t < 20);
      tick();
      if (bus.step_en) begin
        np++;
        if (first_t < 0) first_t = t;
      end
    end
    chk("step_latency", first_t, 7);
    chk("step_once", np, 1);
    chk("step_count_1", bus.step_count, 1);
    chk("idle_not_running", bus.running, 0);

    // Manual register select table.
    vecs[0] = '{1'b0, 5'd0,  5'd0};
    vecs[1] = '{1'b0, 5'd31, 5'd31};
    vecs[2] = '{1'b0, 5'd17, 5'd17};
    vecs[3] = '{1'b0, 5'd5,  5'd5};
    vecs[4] = '{1'b1, 5'd20, 5'd5};
    vecs[5] = '{1'b0, 5'd12, 5'd12};
    for (int i = 0; i < 6; i++) begin
      sw_scan = vecs[i].scan;
      sw_sel  = vecs[i].sel;
      tick();
      chk($sformatf("regsel_vec%0d", i), bus.reg_sel, vecs[i].exp_sel);
    end
    sw_scan = 1'b0; sw_sel = '0;

    // Free-run: period 8, five pulses, second run press drops the due step.
    do_reset();
    np = 0;
    for (int t = 0; t < 90; t++) begin
      key_run_n = !((t < 8) || (t >= 48 && t < 56));
      tick();
      if (bus.step_en) begin
        if (np < 8) pt[np] = t;
        np++;
      end
      if (t == 7)  chk("run_enter", bus.running, 1);
      if (t == 48) chk("run_count5", bus.step_count, 5);
      if (t == 54) chk("run_still", bus.running, 1);
      if (t == 55) chk("run_exit", bus.running, 0);
    end
    chk("run_npulses", np, 5);
    for (int k = 0; k < 5 && k < np; k++) chk($sformatf("run_pulse%0d_t", k), pt[k], 15 + 8 * k);
    chk("run_final_count", bus.step_count, 5);

    // Breakpoint: 4th due step suppressed, run press leaves the bp PC.
    do_reset();
    bp_en = 1'b1; bp_addr = 8'h0C;
    np = 0;
    for (int t = 0; t < 96; t++) begin
      key_run_n  = !((t < 8) || (t >= 50 && t < 58));
      key_step_n = !(t >= 80 && t < 88);
      bus.pc_value = (t >= 32) ? 32'h0000_000C : 32'h0;
      tick();
      if (bus.step_en) np++;
      if (t == 39) begin
        chk("bp_suppress", bus.step_en, 0);
        chk("bp_hit", bus.bp_hit, 1);
        chk("bp_not_running", bus.running, 0);
      end
      if (t == 57) begin
        chk("bp_resume_running", bus.running, 1);
        chk("bp_resume_clear", bus.bp_hit, 0);
      end
      if (t == 65) chk("bp_first_step", bus.step_en, 1);
      if (t == 73) chk("bp_rehit", {bus.bp_hit, bus.step_en}, 2);
      if (t == 87) chk("bp_single_step", {bus.bp_hit, bus.step_en}, 3);
    end
    chk("bp_npulses", np, 5);
    chk("bp_count", bus.step_count, 5);
    bp_en = 1'b0; bus.pc_value = '0;

    // Auto-scan from 30 with wrap, then back to switches.
    sw_sel = 5'd30; sw_scan = 1'b0;
    tick();
    chk("scan_preload", bus.reg_sel, 30);
    for (int t = 0; t < 16; t++) begin
      sw_scan = (t < 15);
      sw_sel  = (t < 15) ? 5'd30 : 5'd7;
      tick();
      if (t == 3)  chk("scan_hold30", bus.reg_sel, 30);
      if (t == 4)  chk("scan_31", bus.reg_sel, 31);
      if (t == 8)  chk("scan_hold31", bus.reg_sel, 31);
      if (t == 9)  chk("scan_wrap0", bus.reg_sel, 0);
      if (t == 14) chk("scan_1", bus.reg_sel, 1);
      if (t == 15) chk("scan_exit_sw7", bus.reg_sel, 7);
    end

    // Reset mid-run interval.
    do_reset();
    sw_sel = 5'd9;
    np = 0;
    for (int t = 0; t < 40; t++) begin
      key_run_n = !(t < 8);
      reset = (t == 27);
      tick();
      if (t == 23) chk("rst_pre_step", bus.step_en, 1);
      if (t == 26) chk("rst_pre_running", bus.running, 1);
      if (t == 27) begin
        chk("rst_running", bus.running, 0);
        chk("rst_count", bus.step_count, 0);
        chk("rst_regsel", bus.reg_sel, 0);
        chk("rst_step_en", bus.step_en, 0);
      end
      if (t == 28) begin
        chk("rst_step_en_next", bus.step_en, 0);
        chk("rst_regsel_sw", bus.reg_sel, 9);
      end
      if (t >= 27 && bus.step_en) np++;
    end
    chk("rst_no_steps_after", np, 0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
